// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bit-index counter width; never below one bit so the counter stays declarable.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bi, with borrow-out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bi;
  assign bo      = (~a & b) | (~a_xor_b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {B, D} = x - y - b_in, one bit per clock, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] dr_shifted;

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  full_subtractor u_cell (
    .a  (xr_q[0]),
    .b  (yr_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign dr_shifted = (dr_q >> 1) | {cell_d, (WIDTH-1)'(0)};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    xr_d   = xr_q;
    yr_d   = yr_q;
    dr_d   = dr_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);

    if (accept) begin
      xr_d  = x;
      yr_d  = y;
      br_d  = b_in;
      dr_d  = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      xr_d = xr_q >> 1;
      yr_d = yr_q >> 1;
      dr_d = dr_shifted;
      br_d = cell_bo;
      if (last_bit) begin
        diff_d = dr_shifted;
        bout_d = cell_bo;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr_q   <= '0;
      yr_q   <= '0;
      dr_q   <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      xr_q   <= xr_d;
      yr_q   <= yr_d;
      dr_q   <= dr_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = diff_q;
  assign B    = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor that computes D = x − y − b_in one bit per clock, LSB first, using a single registered borrow. It is the inverse-operation companion to the team's combinational 4-bit adder, {C, S} = x + y + c. It is intended for area-constrained datapaths that trade latency for a single 1-bit full-subtractor cell. A start/done handshake frames each operation.

## Interface
- WIDTH, default 4: operand and difference width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  minuend; sampled on the accepting edge only.
- y  input  WIDTH  subtrahend; sampled on the accepting edge only.
- b_in  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed (SHIFT).
- done  output  1  one-cycle pulse; D and B are valid from this cycle on.
- D  output  WIDTH  difference; registered, held until the next completion.
- B  output  1  borrow-out; registered, held until the next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE + start=1:
  - latch x into xr and y into yr; load br = b_in; clear cnt and the difference shift register dr;
  - go to SHIFT.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- SHIFT, each cycle:
  - compute d = xr[0] ^ yr[0] ^ br;
  - next borrow = (~xr[0] & yr[0]) | (~(xr[0] ^ yr[0]) & br);
  - shift xr and yr right by 1;
  - shift d into the MSB of dr;
  - cnt += 1.
- SHIFT, on the edge that processes bit WIDTH−1:
  - load D with the final dr value;
  - load B with the final borrow;
  - go to DONE.
- start while in SHIFT: ignored and not queued; x, y and b_in changes in SHIFT have no effect.
- Arithmetic: {B, D} equals the (WIDTH+1)-bit two's-complement value of x − y − b_in. B = 1 exactly when x < y + b_in (unsigned compare).
- cnt width: $clog2(WIDTH); wrap is impossible because SHIFT exits at WIDTH−1.
- Reset (any time, including mid-SHIFT):
  - state=IDLE; busy=0, done=0, D=0, B=0;
  - internal xr, yr, dr, br and cnt cleared;
  - an aborted operation produces no done.

## Timing
- Accepting edge T0: busy=1 from T0 through the cycle before edge T0+WIDTH.
- Edge T0+WIDTH: D and B update, done=1, busy=0.
- Latency from the start-sampling edge to done: WIDTH cycles.
- Edge T0+WIDTH+1: done=0. If start=1 in DONE, the next operation is accepted on this edge (back-to-back).
- Throughput: one result per WIDTH+1 cycles.
- D and B change only at completion edges; they never show partial results.
- Reset values: busy=0, done=0, D=0, B=0.

## Structure
- Package serial_subtractor_pkg: state enum (IDLE, SHIFT, DONE) and a localparam helper for the counter width.
- Sub-module full_subtractor: combinational 1-bit cell with inputs a, b, bi and outputs d, bo. It is instantiated once in the SHIFT datapath.
- Everything else stays in one always_ff block plus next-state logic.

## Test plan
- WIDTH=4; x=9, y=3, b_in=0; start pulse:
  - done occurs exactly 4 cycles after the accepting edge;
  - D=6, B=0;
  - busy is high for 4 cycles.
- x=3, y=9, b_in=0 → D=4'hA, B=1.
- Borrow-in cases:
  - x=0, y=0, b_in=1 → D=4'hF, B=1;
  - x=15, y=15, b_in=1 → D=4'hF, B=1;
  - x=15, y=0, b_in=0 → D=4'hF, B=0.
- Back-to-back and busy behaviour:
  - start held high continuously with 5−2 then 7−7 → two done pulses 5 cycles apart, D=3 then D=0;
  - a start pulse mid-SHIFT with different operands is ignored.
- Reset mid-operation:
  - assert rst_n=0 asynchronously 2 cycles after start;
  - outputs go to 0 immediately and no done occurs;
  - after release, a new 8−1 operation gives D=7, B=0.
- Random sweep, WIDTH=4 and WIDTH=8 (exhaustive for 4): {B, D} must equal x − y − b_in mod 2^(WIDTH+1) on every done.
